// File: rtl/mr1_mem_arbiter.sv
// mr1_mem_arbiter
//   Merges the MR1 instruction-fetch and load/store request ports onto one
//   shared memory request port. Round-robin arbitration is purely
//   combinational, so a request can be accepted in the cycle it is presented.
//   An in-order tag FIFO records the source of every read that is issued.
//   The FIFO head tag steers each read response back to the port that asked
//   for it.
module mr1_mem_arbiter #(
    parameter int MAX_OUTSTANDING = 2   // reads in flight, power of 2, >= 1
) (
    input  logic        clk,
    input  logic        reset,          // synchronous, active-low

    input  logic        instr_req_valid,
    output logic        instr_req_ready,
    input  logic [31:0] instr_req_addr,
    output logic        instr_rsp_valid,
    output logic [31:0] instr_rsp_data,

    input  logic        data_req_valid,
    output logic        data_req_ready,
    input  logic        data_req_wr,
    input  logic [1:0]  data_req_size,
    input  logic [31:0] data_req_addr,
    input  logic [31:0] data_req_data,
    output logic        data_rsp_valid,
    output logic [31:0] data_rsp_data,

    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic        mem_req_wr,
    output logic [1:0]  mem_req_size,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_data,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,

    output logic        rsp_orphan_err
);

    // The pointers carry one extra wrap bit so that full and empty can be told apart.
    localparam int IDX_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic {
        SRC_INSTR = 1'b0,
        SRC_DATA  = 1'b1
    } src_e;

    src_e             last_grant;
    src_e             tag_mem [DEPTH];
    src_e             push_tag;
    src_e             head_tag;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] fifo_count;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             fifo_full;
    logic             fifo_empty;
    logic             instr_elig;
    logic             data_elig;
    logic             grant_instr;
    logic             grant_data;
    logic             push;
    logic             pop;
    logic             rsp_hit;

    assign fifo_empty = (wr_ptr == rd_ptr);
    // The pointers differ only in the wrap bit exactly when the FIFO holds MAX_OUTSTANDING tags.
    assign fifo_full  = ((wr_ptr ^ rd_ptr) == PTR_W'(MAX_OUTSTANDING));
    assign fifo_count = wr_ptr - rd_ptr;
    assign wr_idx     = IDX_W'(wr_ptr);
    assign rd_idx     = IDX_W'(rd_ptr);
    assign head_tag   = tag_mem[rd_idx];

    // Eligibility and round-robin winner selection; nothing is granted while in reset.
    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a value on every path, otherwise a latch is inferred.
        instr_elig  = reset & instr_req_valid & ~fifo_full;
        data_elig   = reset & data_req_valid & (data_req_wr | ~fifo_full);
        grant_data  = data_elig & (~instr_elig | (last_grant == SRC_INSTR));
        grant_instr = instr_elig & ~grant_data;
    end

    // Shared request mux, per-port handshake and the tag push decision.
    always_comb begin
        mem_req_valid   = grant_instr | grant_data;
        mem_req_wr      = 1'b0;
        mem_req_size    = 2'd2;
        mem_req_addr    = instr_req_addr;
        mem_req_data    = 32'h0;
        if (grant_data) begin
            mem_req_wr   = data_req_wr;
            mem_req_size = data_req_size;
            mem_req_addr = data_req_addr;
            mem_req_data = data_req_data;
        end
        instr_req_ready = grant_instr & mem_req_ready;
        data_req_ready  = grant_data & mem_req_ready;
        push            = mem_req_valid & mem_req_ready & (grant_instr | ~data_req_wr);
        push_tag        = grant_data ? SRC_DATA : SRC_INSTR;
    end

    // Response steering: the FIFO head tag picks which port sees the read data.
    always_comb begin
        rsp_hit         = reset & mem_rsp_valid & ~fifo_empty;
        pop             = rsp_hit;
        instr_rsp_valid = rsp_hit & (head_tag == SRC_INSTR);
        data_rsp_valid  = rsp_hit & (head_tag == SRC_DATA);
        instr_rsp_data  = mem_rsp_data;
        data_rsp_data   = mem_rsp_data;
    end

    // Control state: arbitration history, FIFO pointers and the sticky orphan flag.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so that every register samples pre-edge values.
        if (!reset) begin
            last_grant     <= SRC_INSTR;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            rsp_orphan_err <= 1'b0;
        end else begin
            if (mem_req_valid && mem_req_ready) begin
                last_grant <= push_tag;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (mem_rsp_valid && fifo_empty) begin
                rsp_orphan_err <= 1'b1;
            end
        end
    end

    // Tag storage; only the locations between the pointers are meaningful.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; emptying the pointers is enough to discard its contents.
        if (push) begin
            tag_mem[wr_idx] <= push_tag;
        end
    end

    // Invariants: responses go to one port at a time, and the tag count never exceeds the FIFO depth.
    a_one_rsp : assert property (@(posedge clk) disable iff (!reset)
        !(instr_rsp_valid && data_rsp_valid));
    a_count_bound : assert property (@(posedge clk) disable iff (!reset)
        fifo_count <= PTR_W'(MAX_OUTSTANDING));
    c_fifo_full : cover property (@(posedge clk) disable iff (!reset) fifo_full);

endmodule

// File: tb/tb_mr1_mem_arbiter.sv
// tb_mr1_mem_arbiter
//   Randomized traffic on both MR1 ports plus a bench-side memory that answers
//   reads in order. A reference model predicts grants from the arbitration
//   rules and the number of reads in flight. Each issued read pushes its
//   expected (port, data) pair into a scoreboard queue, and a separate monitor
//   pops that queue whenever the memory returns data.
module tb_mr1_mem_arbiter;

    localparam int MAX = 2;

    logic        clk;
    logic        reset;
    logic        instr_req_valid;
    logic        instr_req_ready;
    logic [31:0] instr_req_addr;
    logic        instr_rsp_valid;
    logic [31:0] instr_rsp_data;
    logic        data_req_valid;
    logic        data_req_ready;
    logic        data_req_wr;
    logic [1:0]  data_req_size;
    logic [31:0] data_req_addr;
    logic [31:0] data_req_data;
    logic        data_rsp_valid;
    logic [31:0] data_rsp_data;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wr;
    logic [1:0]  mem_req_size;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_data;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        rsp_orphan_err;

    mr1_mem_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
        .clk             (clk),
        .reset           (reset),
        .instr_req_valid (instr_req_valid),
        .instr_req_ready (instr_req_ready),
        .instr_req_addr  (instr_req_addr),
        .instr_rsp_valid (instr_rsp_valid),
        .instr_rsp_data  (instr_rsp_data),
        .data_req_valid  (data_req_valid),
        .data_req_ready  (data_req_ready),
        .data_req_wr     (data_req_wr),
        .data_req_size   (data_req_size),
        .data_req_addr   (data_req_addr),
        .data_req_data   (data_req_data),
        .data_rsp_valid  (data_rsp_valid),
        .data_rsp_data   (data_rsp_data),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_wr      (mem_req_wr),
        .mem_req_size    (mem_req_size),
        .mem_req_addr    (mem_req_addr),
        .mem_req_data    (mem_req_data),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_data    (mem_rsp_data),
        .rsp_orphan_err  (rsp_orphan_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          to_data;   // 0 = fetch port, 1 = load/store port
        logic [31:0] data;
    } rsp_t;

    rsp_t        exp_q[$];      // scoreboard: responses owed, oldest first
    logic [31:0] pend_q[$];     // bench memory: read data still to be returned

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int inflight = 0;           // reads issued and not yet answered
    bit last_win = 1'b0;        // 0 = fetch port won last, 1 = data port
    bit exp_err  = 1'b0;

    // Stimulus knobs (percent probabilities)
    int p_iv, p_dv, p_wr, p_rdy, p_rsp;
    bit fixed_addr = 1'b0;
    bit inj_orphan = 1'b0;
    bit i_acc, d_acc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Drive one cycle of inputs; MR1 holds a request until it is accepted.
    task automatic drive_inputs();
        if (!instr_req_valid || i_acc) begin
            instr_req_valid = ($urandom_range(0, 99) < p_iv);
            instr_req_addr  = fixed_addr ? 32'h100 : $urandom;
        end
        if (!data_req_valid || d_acc) begin
            data_req_valid = ($urandom_range(0, 99) < p_dv);
            data_req_wr    = ($urandom_range(0, 99) < p_wr);
            data_req_size  = fixed_addr ? 2'd2 : 2'($urandom_range(0, 2));
            data_req_addr  = fixed_addr ? 32'h200 : $urandom;
            data_req_data  = $urandom;
        end
        mem_req_ready = ($urandom_range(0, 99) < p_rdy);
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = $urandom;
        if (pend_q.size() > 0 && $urandom_range(0, 99) < p_rsp) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = pend_q.pop_front();
        end else if (inj_orphan && pend_q.size() == 0) begin
            mem_rsp_valid = 1'b1;
            inj_orphan    = 1'b0;
        end
    endtask

    task automatic run(input int n, input int iv, input int dv, input int wr,
                       input int rdy, input int rsp);
        p_iv = iv; p_dv = dv; p_wr = wr; p_rdy = rdy; p_rsp = rsp;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            i_acc = instr_req_valid & instr_req_ready;
            d_acc = data_req_valid & data_req_ready;
            @(posedge clk);
            #1;
            drive_inputs();
        end
    endtask

    // Reset while the memory may still owe responses; those arrive afterwards as orphans.
    task automatic do_reset(input int cycles);
        @(posedge clk);
        #1;
        reset           = 1'b0;
        instr_req_valid = 1'b0;
        data_req_valid  = 1'b0;
        mem_rsp_valid   = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Reference model: predicts the shared request and per-port readies from the arbitration rules.
    always @(negedge clk) begin
        bit          i_el, d_el, any, win_data, exp_wr;
        logic [1:0]  exp_size;
        logic [31:0] exp_addr, exp_data, rd;
        if (!reset) begin
            check("reset_mem_req_valid", mem_req_valid, 0);
            check("reset_instr_req_ready", instr_req_ready, 0);
            check("reset_data_req_ready", data_req_ready, 0);
            check("reset_instr_rsp_valid", instr_rsp_valid, 0);
            check("reset_data_rsp_valid", data_rsp_valid, 0);
            inflight = 0;
            last_win = 1'b0;
            exp_q.delete();
        end else begin
            i_el = instr_req_valid && (inflight < MAX);
            d_el = data_req_valid && (data_req_wr || inflight < MAX);
            any  = i_el || d_el;
            win_data = (i_el && d_el) ? !last_win : d_el;
            check("mem_req_valid", mem_req_valid, any);
            check("instr_req_ready", instr_req_ready, any && !win_data && mem_req_ready);
            check("data_req_ready", data_req_ready, any && win_data && mem_req_ready);
            if (any) begin
                exp_wr   = win_data ? data_req_wr   : 1'b0;
                exp_size = win_data ? data_req_size : 2'd2;
                exp_addr = win_data ? data_req_addr : instr_req_addr;
                exp_data = win_data ? data_req_data : 32'h0;
                check("mem_req_wr", mem_req_wr, exp_wr);
                check("mem_req_size", mem_req_size, exp_size);
                check("mem_req_addr", mem_req_addr, exp_addr);
                check("mem_req_data", mem_req_data, exp_data);
                if (mem_req_ready) begin
                    last_win = win_data;
                    if (!exp_wr) begin
                        rd = $urandom;
                        exp_q.push_back('{to_data: win_data, data: rd});
                        pend_q.push_back(rd);
                        inflight++;
                    end
                end
            end
            if (mem_rsp_valid && inflight > 0) inflight--;
        end
    end

    // Response monitor: pops the scoreboard whenever the memory returns data.
    always @(negedge clk) begin
        rsp_t e;
        if (!reset) begin
            exp_err = 1'b0;
        end else begin
            check("rsp_orphan_err", rsp_orphan_err, exp_err);
            check("instr_rsp_data_pass", instr_rsp_data, mem_rsp_data);
            check("data_rsp_data_pass", data_rsp_data, mem_rsp_data);
            if (mem_rsp_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("instr_rsp_valid", instr_rsp_valid, !e.to_data);
                check("data_rsp_valid", data_rsp_valid, e.to_data);
                check("rsp_data", e.to_data ? data_rsp_data : instr_rsp_data, e.data);
            end else begin
                check("idle_rsp_valids", {instr_rsp_valid, data_rsp_valid}, 0);
                if (mem_rsp_valid) exp_err = 1'b1;
            end
        end
    end

    initial begin
        reset           = 1'b0;
        instr_req_valid = 1'b0;
        instr_req_addr  = 32'h0;
        data_req_valid  = 1'b0;
        data_req_wr     = 1'b0;
        data_req_size   = 2'd0;
        data_req_addr   = 32'h0;
        data_req_data   = 32'h0;
        mem_req_ready   = 1'b1;
        mem_rsp_valid   = 1'b0;
        mem_rsp_data    = 32'h0;
        i_acc           = 1'b0;
        d_acc           = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;

        // Both ports always requesting loads/fetches at fixed addresses: grants alternate, DATA first.
        fixed_addr = 1'b1;
        run(20, 100, 100, 0, 100, 100);
        // Fetch-only traffic at the fixed address.
        run(8, 100, 0, 0, 100, 100);
        fixed_addr = 1'b0;
        // No responses: the FIFO fills, reads stall while stores keep flowing.
        run(16, 100, 100, 50, 100, 0);
        // Drain the outstanding reads, then let a blocked load through.
        run(10, 0, 100, 0, 100, 100);
        run(6, 0, 0, 0, 100, 100);
        // A response with nothing outstanding is an orphan and the flag stays set.
        inj_orphan = 1'b1;
        run(6, 0, 0, 0, 100, 0);
        // Random traffic with back-pressure and variable response delay.
        run(3000, 60, 60, 40, 70, 40);
        // Build up outstanding reads, reset, then let the stale responses arrive as orphans.
        run(6, 100, 100, 0, 100, 0);
        do_reset(2);
        run(12, 0, 0, 0, 100, 100);
        run(400, 60, 60, 30, 80, 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
